// File: rtl/fetch_hazard_ctrl.sv
// Pipeline sequencing controller for the IF stage of a five-stage MIPS32 core.
// Detects load-use hazards (stall + bubble), squashes ID/EX on a taken branch
// resolved in EX/MEM, and drains the pipeline after an HLT before raising HALTED.
//
// Ports:
//   clk, rst_n     pipeline clock, asynchronous active-low reset
//   IF_ID_IR       instruction in IF/ID
//   ID_EX_IR       instruction in ID/EX
//   EX_MEM_IR      instruction in EX/MEM
//   EX_MEM_COND    branch condition flag (register == 0) from EX/MEM
//   PCWrite        PC update enable (combinational)
//   IF_ID_Write    IF/ID write enable (combinational)
//   ID_EX_Bubble   load a NOP into ID/EX instead of the decoded instruction (combinational)
//   ID_EX_Flush    clear ID/EX on a wrong-path squash (combinational)
//   HALTED         registered, sticky until reset
//   stall_count    registered, saturating count of load-use stall cycles
module fetch_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_ID_IR,
    input  logic [31:0]      ID_EX_IR,
    input  logic [31:0]      EX_MEM_IR,
    input  logic             EX_MEM_COND,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             ID_EX_Flush,
    output logic             HALTED,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DCNT_W = 4;

    localparam logic [OP_W-1:0] OP_LW     = 6'b001000;
    localparam logic [OP_W-1:0] OP_SW     = 6'b001001;
    localparam logic [OP_W-1:0] OP_RR_MAX = 6'b000101;
    localparam logic [OP_W-1:0] OP_BNEQZ  = 6'b001101;
    localparam logic [OP_W-1:0] OP_BEQZ   = 6'b001110;
    localparam logic [OP_W-1:0] OP_HLT    = 6'b111111;

    // Drain counter is 4 bits wide; reject out-of-range drain lengths at elaboration.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
    logic                halted_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                pcw_c, ifw_c, bub_c, flush_c, stall_inc_c;

    // Instruction field decode.
    logic [OP_W-1:0]  if_op, ex_op, mem_op;
    logic [REG_W-1:0] if_rs, if_rt, ex_rt;

    assign if_op  = IF_ID_IR[31:26];
    assign if_rs  = IF_ID_IR[25:21];
    assign if_rt  = IF_ID_IR[20:16];
    assign ex_op  = ID_EX_IR[31:26];
    assign ex_rt  = ID_EX_IR[20:16];
    assign mem_op = EX_MEM_IR[31:26];

    // Fields not needed for hazard detection.
    logic unused_fields;
    assign unused_fields = ^{IF_ID_IR[15:0], ID_EX_IR[25:21], ID_EX_IR[15:0], EX_MEM_IR[25:0]};

    logic branch_taken, load_use, hlt_seen, if_reads_rt;

    assign branch_taken = ((mem_op == OP_BNEQZ) && !EX_MEM_COND) ||
                          ((mem_op == OP_BEQZ)  &&  EX_MEM_COND);

    // RR ops and SW read rt as a source; other I-types write it.
    assign if_reads_rt  = (if_op <= OP_RR_MAX) || (if_op == OP_SW);
    assign load_use     = (ex_op == OP_LW) && (ex_rt != '0) &&
                          ((ex_rt == if_rs) || (if_reads_rt && (ex_rt == if_rt)));
    assign hlt_seen     = (if_op == OP_HLT);

    // Next-state and hazard outputs; priority is branch > HLT > load-use.
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        pcw_c       = 1'b0;
        ifw_c       = 1'b0;
        bub_c       = 1'b0;
        flush_c     = 1'b0;
        stall_inc_c = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    flush_c = 1'b1;
                    pcw_c   = 1'b1;
                    ifw_c   = 1'b1;
                end else if (hlt_seen) begin
                    dcnt_nxt  = DCNT_W'(DRAIN_CYCLES);
                    state_nxt = DRAIN;
                end else if (load_use) begin
                    bub_c       = 1'b1;
                    stall_inc_c = 1'b1;
                end else begin
                    pcw_c = 1'b1;
                    ifw_c = 1'b1;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    // The HLT was on the wrong path: squash it and resume.
                    flush_c   = 1'b1;
                    pcw_c     = 1'b1;
                    ifw_c     = 1'b1;
                    dcnt_nxt  = '0;
                    state_nxt = RUN;
                end else begin
                    bub_c    = 1'b1;
                    dcnt_nxt = dcnt - DCNT_W'(1);
                    if (dcnt <= DCNT_W'(1)) begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                bub_c = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                dcnt_nxt  = '0;
            end
        endcase
    end

    // State, drain counter, sticky halt flag and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            dcnt     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            dcnt     <= dcnt_nxt;
            halted_q <= (state_nxt == HALT);
            if (stall_inc_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Combinational enables are held low while reset is asserted.
    assign PCWrite      = rst_n & pcw_c;
    assign IF_ID_Write  = rst_n & ifw_c;
    assign ID_EX_Bubble = rst_n & bub_c;
    assign ID_EX_Flush  = rst_n & flush_c;
    assign HALTED       = halted_q;
    assign stall_count  = cnt_q;

endmodule
